// File: rtl/cail_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : cail_param_loader
//  Purpose  : Framed byte-stream loader for the 32x8 calibration-parameter
//             RAM. It parses HEADER/addr/count/data/checksum, stages the
//             payload and writes it to the RAM only when the frame is valid.
//  Revision : 1.0  initial release
// ============================================================================
module cail_param_loader #(
   parameter int         ADDR_W  = 5,
   parameter logic [7:0] HEADER  = 8'hA5,
   parameter int         TIMEOUT = 50000
) (
   input  logic              clock,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic [ADDR_W-1:0] wraddress,
   output logic [7:0]        data,
   output logic              wren,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [1:0]        err_code
);

   localparam int DEPTH = 1 << ADDR_W;
   // The byte counter must hold DEPTH itself, hence one extra bit.
   localparam int CNT_W = ADDR_W + 1;
   localparam int TO_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   localparam logic [TO_W-1:0] c_TO_LAST     = TO_W'(TIMEOUT - 1);
   localparam logic [1:0]      c_ERR_COUNT   = 2'd1;
   localparam logic [1:0]      c_ERR_CHK     = 2'd2;
   localparam logic [1:0]      c_ERR_TIMEOUT = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ADDR   = 3'd1,
      S_COUNT  = 3'd2,
      S_DATA   = 3'd3,
      S_CHK    = 3'd4,
      S_COMMIT = 3'd5,
      S_FAIL   = 3'd6
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   start_q, start_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [CNT_W-1:0]    idx_q, idx_d;
   logic [7:0]          chk_q, chk_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic [1:0]          fcode_q, fcode_d;

   logic [ADDR_W-1:0]   wraddress_q, wraddress_d;
   logic [7:0]          data_q, data_d;
   logic                wren_q, wren_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_q, err_d;
   logic [1:0]          err_code_q, err_code_d;

   logic [7:0]          stage_q [DEPTH];
   logic                w_stage_we;
   logic                w_parsing;
   logic                w_idle_cyc;
   logic                w_to_hit;
   logic                w_cnt_bad;

   // The inter-byte timeout only runs while a frame is being received.
   assign w_parsing  = (state_q == S_ADDR) || (state_q == S_COUNT) ||
                       (state_q == S_DATA) || (state_q == S_CHK);
   assign w_idle_cyc = w_parsing && !rx_valid;
   assign w_to_hit   = w_idle_cyc && (to_q == c_TO_LAST);
   // Counts of zero or larger than the RAM cannot be framed correctly.
   assign w_cnt_bad  = (rx_data == 8'd0) || ({24'd0, rx_data} > 32'(DEPTH));

   // Next-state logic, frame parsing, checksum tracking and output staging.
   always_comb begin
      state_d     = state_q;
      start_d     = start_q;
      cnt_d       = cnt_q;
      idx_d       = idx_q;
      chk_d       = chk_q;
      fcode_d     = fcode_q;
      to_d        = w_idle_cyc ? (to_q + TO_W'(1)) : '0;
      wraddress_d = wraddress_q;
      data_d      = data_q;
      wren_d      = 1'b0;
      done_d      = 1'b0;
      err_d       = 1'b0;
      err_code_d  = err_code_q;
      w_stage_we  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (rx_valid && (rx_data == HEADER)) begin
               state_d = S_ADDR;
            end
         end

         S_ADDR: begin
            if (rx_valid) begin
               // Upper address bits are dropped; the checksum still covers them.
               start_d = rx_data[ADDR_W-1:0];
               chk_d   = rx_data;
               state_d = S_COUNT;
            end else if (w_to_hit) begin
               fcode_d = c_ERR_TIMEOUT;
               state_d = S_FAIL;
            end
         end

         S_COUNT: begin
            if (rx_valid) begin
               if (w_cnt_bad) begin
                  fcode_d = c_ERR_COUNT;
                  state_d = S_FAIL;
               end else begin
                  cnt_d   = rx_data[CNT_W-1:0];
                  chk_d   = chk_q ^ rx_data;
                  idx_d   = '0;
                  state_d = S_DATA;
               end
            end else if (w_to_hit) begin
               fcode_d = c_ERR_TIMEOUT;
               state_d = S_FAIL;
            end
         end

         S_DATA: begin
            if (rx_valid) begin
               w_stage_we = 1'b1;
               chk_d      = chk_q ^ rx_data;
               if (idx_q == (cnt_q - CNT_W'(1))) begin
                  idx_d   = '0;
                  state_d = S_CHK;
               end else begin
                  idx_d   = idx_q + CNT_W'(1);
               end
            end else if (w_to_hit) begin
               fcode_d = c_ERR_TIMEOUT;
               state_d = S_FAIL;
            end
         end

         S_CHK: begin
            if (rx_valid) begin
               idx_d = '0;
               if (rx_data == chk_q) begin
                  state_d = S_COMMIT;
               end else begin
                  fcode_d = c_ERR_CHK;
                  state_d = S_FAIL;
               end
            end else if (w_to_hit) begin
               fcode_d = c_ERR_TIMEOUT;
               state_d = S_FAIL;
            end
         end

         S_COMMIT: begin
            // One staged byte per clock; incoming bytes are ignored here.
            if (idx_q == cnt_q) begin
               done_d  = 1'b1;
               state_d = S_IDLE;
            end else begin
               wren_d      = 1'b1;
               wraddress_d = start_q + idx_q[ADDR_W-1:0];
               data_d      = stage_q[idx_q[ADDR_W-1:0]];
               idx_d       = idx_q + CNT_W'(1);
            end
         end

         S_FAIL: begin
            err_d      = 1'b1;
            err_code_d = fcode_q;
            state_d    = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   // State, counters and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= S_IDLE;
         start_q     <= '0;
         cnt_q       <= '0;
         idx_q       <= '0;
         chk_q       <= '0;
         to_q        <= '0;
         fcode_q     <= '0;
         wraddress_q <= '0;
         data_q      <= '0;
         wren_q      <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
         err_code_q  <= '0;
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         cnt_q       <= cnt_d;
         idx_q       <= idx_d;
         chk_q       <= chk_d;
         to_q        <= to_d;
         fcode_q     <= fcode_d;
         wraddress_q <= wraddress_d;
         data_q      <= data_d;
         wren_q      <= wren_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         err_q       <= err_d;
         err_code_q  <= err_code_d;
      end
   end

   // Payload staging buffer; contents only matter once a frame validates.
   always_ff @(posedge clock) begin
      if (w_stage_we) begin
         stage_q[idx_q[ADDR_W-1:0]] <= rx_data;
      end
   end

   assign wraddress = wraddress_q;
   assign data      = data_q;
   assign wren      = wren_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign err       = err_q;
   assign err_code  = err_code_q;

endmodule
`default_nettype wire

// File: tb/tb_cail_param_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cail_param_loader
//  Purpose  : Self-checking bench for cail_param_loader: frame table plus
//             hand-written timeout, reset-in-commit and drop-in-commit cases.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cail_param_loader;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic [4:0] wraddress;
   logic [7:0] data;
   logic       wren, busy, done, err;
   logic [1:0] err_code;

   cail_param_loader #(
      .ADDR_W  (5),
      .HEADER  (8'hA5),
      .TIMEOUT (100)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .wraddress (wraddress),
      .data      (data),
      .wren      (wren),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .err_code  (err_code)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [127:0] raw;      // frame bytes, right-aligned, first byte leftmost
      int           len;
      int           off;      // index of the header byte within raw
      int           gap;      // idle cycles between bytes
      bit           exp_err;
      logic [1:0]   exp_code;
   } vec_t;

   typedef struct packed {
      logic [4:0] addr;
      logic [7:0] data;
   } wr_t;

   wr_t        sbq[$];
   logic [7:0] txq[$];
   logic [7:0] ram [32];

   int total, bad, cyc;
   int wren_cnt, done_cnt, err_cnt;
   int first_wren_cyc, done_cyc, err_cyc;
   logic [1:0] last_code;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic monitor();
      check("done_err_exclusive", {31'd0, done & err}, 32'd0);
      if (wren === 1'b1) begin
         wren_cnt++;
         if (first_wren_cyc < 0) first_wren_cyc = cyc;
         ram[wraddress] = data;
         if (sbq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_write: got addr %0h data %0h, expected no write",
                     wraddress, data);
         end else begin
            wr_t e;
            e = sbq.pop_front();
            check("wr_addr", {27'd0, wraddress}, {27'd0, e.addr});
            check("wr_data", {24'd0, data}, {24'd0, e.data});
         end
      end
      if (done === 1'b1) begin
         done_cnt++;
         done_cyc = cyc;
         check("busy_low_at_done", {31'd0, busy}, 32'd0);
      end
      if (err === 1'b1) begin
         err_cnt++;
         err_cyc   = cyc;
         last_code = err_code;
         check("busy_low_at_err", {31'd0, busy}, 32'd0);
      end
   endtask

   task automatic cycle(input bit v, input logic [7:0] d);
      @(negedge clock);
      cyc++;
      monitor();
      rx_valid = v;
      rx_data  = d;
   endtask

   task automatic clear_track();
      wren_cnt       = 0;
      done_cnt       = 0;
      err_cnt        = 0;
      first_wren_cyc = -1;
      done_cyc       = -1;
      err_cyc        = -1;
   endtask

   task automatic push_writes(input int off);
      int n;
      logic [4:0] a;
      n = int'(txq[off+2]);
      for (int i = 0; i < n; i++) begin
         wr_t e;
         a = txq[off+1][4:0] + 5'(i);
         e.addr = a;
         e.data = txq[off+3+i];
         sbq.push_back(e);
      end
   endtask

   // Sends txq, waits for the outcome and checks result, latency and writes.
   task automatic run_frame(input string name, input int off, input int gap,
                            input bit exp_err, input logic [1:0] exp_code);
      int n, c0;
      clear_track();
      n = 0;
      if (!exp_err) begin
         n = int'(txq[off+2]);
         push_writes(off);
      end
      for (int i = 0; i < txq.size(); i++) begin
         cycle(1'b1, txq[i]);
         if (i == off + 1) check({name, "/busy_after_header"}, {31'd0, busy}, 32'd1);
         if (i != txq.size() - 1) begin
            for (int g = 0; g < gap; g++) cycle(1'b0, 8'h00);
         end
      end
      c0 = cyc;
      for (int k = 0; k < 80 && done_cnt == 0 && err_cnt == 0; k++) cycle(1'b0, 8'h00);
      repeat (3) cycle(1'b0, 8'h00);
      check({name, "/done_count"}, done_cnt, {31'd0, !exp_err});
      check({name, "/err_count"}, err_cnt, {31'd0, exp_err});
      if (exp_err) begin
         check({name, "/err_code"}, {30'd0, last_code}, {30'd0, exp_code});
         check({name, "/err_latency"}, err_cyc, c0 + 2);
         check({name, "/no_writes"}, wren_cnt, 0);
      end else begin
         check({name, "/write_count"}, wren_cnt, n);
         check({name, "/first_write_latency"}, first_wren_cyc, c0 + 2);
         check({name, "/done_latency"}, done_cyc, first_wren_cyc + n);
      end
      check({name, "/scoreboard_empty"}, sbq.size(), 0);
      sbq.delete();
   endtask

   vec_t tbl[7];

   initial begin
      int k;
      logic [7:0] x;
      total = 0; bad = 0; cyc = 0;
      clear_track();
      last_code = 2'd0;
      for (int i = 0; i < 32; i++) ram[i] = 8'h00;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

      tbl[0] = '{raw: 128'hA5_00_04_11_22_33_44_40,    len: 8, off: 0, gap: 0, exp_err: 1'b0, exp_code: 2'd0};
      tbl[1] = '{raw: 128'hA5_00_04_11_22_33_44_41,    len: 8, off: 0, gap: 2, exp_err: 1'b1, exp_code: 2'd2};
      tbl[2] = '{raw: 128'h00_FF_5A_A5_05_02_DE_AD_74, len: 9, off: 3, gap: 1, exp_err: 1'b0, exp_code: 2'd0};
      tbl[3] = '{raw: 128'hA5_1E_03_AA_BB_CC_C0,       len: 7, off: 0, gap: 0, exp_err: 1'b0, exp_code: 2'd0};
      tbl[4] = '{raw: 128'hA5_00_00,                   len: 3, off: 0, gap: 3, exp_err: 1'b1, exp_code: 2'd1};
      tbl[5] = '{raw: 128'hA5_00_21,                   len: 3, off: 0, gap: 0, exp_err: 1'b1, exp_code: 2'd1};
      tbl[6] = '{raw: 128'hA5_EC_01_77_9A,             len: 5, off: 0, gap: 1, exp_err: 1'b0, exp_code: 2'd0};

      repeat (3) cycle(1'b0, 8'h00);
      check("reset_outputs", {19'd0, wraddress, data, wren, busy, done, err, err_code}, 32'd0);
      reset = 1'b0;
      repeat (2) cycle(1'b0, 8'h00);

      // Table-driven frames.
      for (int t = 0; t < 7; t++) begin
         txq.delete();
         for (int i = 0; i < tbl[t].len; i++) txq.push_back(tbl[t].raw[(tbl[t].len-1-i)*8 +: 8]);
         run_frame($sformatf("vec%0d", t), tbl[t].off, tbl[t].gap, tbl[t].exp_err, tbl[t].exp_code);
      end
      check("ram0_wrapped", {24'd0, ram[0]},  32'hCC);
      check("ram1",         {24'd0, ram[1]},  32'h22);
      check("ram3",         {24'd0, ram[3]},  32'h44);
      check("ram6",         {24'd0, ram[6]},  32'hAD);
      check("ram12",        {24'd0, ram[12]}, 32'h77);
      check("ram30",        {24'd0, ram[30]}, 32'hAA);
      check("ram31",        {24'd0, ram[31]}, 32'hBB);

      // Reset asserted in the middle of a commit.
      clear_track();
      txq = '{8'hA5, 8'h10, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h10};
      push_writes(0);
      for (int i = 0; i < txq.size(); i++) cycle(1'b1, txq[i]);
      for (int j = 0; j < 20 && wren_cnt < 2; j++) cycle(1'b0, 8'h00);
      reset = 1'b1;
      cycle(1'b0, 8'h00);
      check("reset_in_commit_outputs", {19'd0, wraddress, data, wren, busy, done, err, err_code}, 32'd0);
      reset = 1'b0;
      sbq.delete();
      repeat (10) cycle(1'b0, 8'h00);
      check("reset_in_commit_writes", wren_cnt, 2);
      check("reset_in_commit_no_done", done_cnt, 0);
      check("reset_ram17", {24'd0, ram[17]}, 32'h02);
      check("reset_ram18_untouched", {24'd0, ram[18]}, 32'h00);

      // Timeout after a stalled data phase, then a normal frame.
      clear_track();
      txq = '{8'hA5, 8'h00, 8'h04, 8'h11};
      for (int i = 0; i < txq.size(); i++) cycle(1'b1, txq[i]);
      k = 0;
      for (int j = 1; j <= 150 && err_cnt == 0; j++) begin
         cycle(1'b0, 8'h00);
         k = j;
      end
      check("timeout_err", err_cnt, 1);
      check("timeout_code", {30'd0, last_code}, 32'd3);
      check("timeout_latency", k, 102);
      check("timeout_no_writes", wren_cnt, 0);
      repeat (2) cycle(1'b0, 8'h00);
      txq = '{8'hA5, 8'h08, 8'h02, 8'h5C, 8'h6D, 8'h3B};
      run_frame("after_timeout", 0, 0, 1'b0, 2'd0);

      // Bytes arriving during commit must not start a new frame.
      clear_track();
      txq = '{8'hA5, 8'h14, 8'h02, 8'h01, 8'h02, 8'h15};
      push_writes(0);
      for (int i = 0; i < txq.size(); i++) cycle(1'b1, txq[i]);
      cycle(1'b1, 8'hA5);
      cycle(1'b1, 8'h00);
      cycle(1'b1, 8'h01);
      for (int j = 0; j < 20 && done_cnt == 0; j++) cycle(1'b0, 8'h00);
      cycle(1'b1, 8'h55);
      cycle(1'b1, 8'h54);
      repeat (12) cycle(1'b0, 8'h00);
      check("drop_done", done_cnt, 1);
      check("drop_err", err_cnt, 0);
      check("drop_writes", wren_cnt, 2);
      check("drop_scoreboard_empty", sbq.size(), 0);
      sbq.delete();

      // Largest legal frame: 32 bytes starting at 8, wrapping to 7.
      txq.delete();
      txq.push_back(8'hA5);
      txq.push_back(8'h08);
      txq.push_back(8'h20);
      x = 8'h08 ^ 8'h20;
      for (int i = 0; i < 32; i++) begin
         txq.push_back(8'(i * 7 + 3));
         x = x ^ 8'(i * 7 + 3);
      end
      txq.push_back(x);
      run_frame("full32", 0, 0, 1'b0, 2'd0);
      check("full32_ram8", {24'd0, ram[8]}, 32'h03);
      check("full32_ram7", {24'd0, ram[7]}, 32'hDC);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/cail_param_loader.md
# cail_param_loader

Frame-based loader that fills the 32x8 calibration-parameter RAM (`cail_param`) from a byte stream, such as a UART receiver. It sits directly upstream of the RAM's write port and drives its `wraddress`, `data` and `wren`. It parses a framed command, stages the payload locally and validates the checksum. Only a fully valid frame is committed to the RAM, one byte per clock, so a corrupt frame never modifies stored parameters.

## Interface
- `ADDR_W`, 5: RAM address width; the RAM and staging buffer are 2^ADDR_W = 32 bytes deep.
- `HEADER`, 8'hA5: frame start byte.
- `TIMEOUT`, 50000: idle clocks allowed between bytes inside a frame (1 ms at 50 MHz).
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `rx_data` in 8: received byte, valid when `rx_valid`=1.
- `rx_valid` in 1: one-cycle byte strobe.
- `wraddress` out ADDR_W: RAM write address.
- `data` out 8: RAM write data.
- `wren` out 1: RAM write enable.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse when a commit completes.
- `err` out 1: one-cycle pulse when a frame is rejected.
- `err_code` out 2: 1 = bad count, 2 = checksum mismatch, 3 = timeout; held until the next `err`.

## Operation
- Frame format: `HEADER`, start address, count N, N data bytes, checksum. The checksum is the XOR of address, count and all data bytes; the header is excluded.
- The address byte's upper 3 bits are ignored; only `addr[4:0]` is used.
- States: IDLE, ADDR, COUNT, DATA, CHK, COMMIT, FAIL.
- IDLE: on `rx_valid` with `rx_data`==HEADER, go to ADDR. Any other byte is discarded silently.
- ADDR: latch the start address, seed the checksum with it, go to COUNT.
- COUNT: if N==0 or N>32, go to FAIL with code 1. Otherwise latch N, XOR it into the checksum and go to DATA.
- DATA: store the i-th byte in `buf[i]`, i = 0..N-1, and XOR it into the checksum. Go to CHK after byte N-1.
- CHK: if the received byte equals the running checksum, go to COMMIT; otherwise go to FAIL with code 2.
- COMMIT: write `buf[i]` to address `(start+i) mod 32` for i = 0..N-1, one write per cycle. Then pulse `done` and return to IDLE.
- FAIL: pulse `err` for one cycle and return to IDLE. The RAM is untouched.
- Timeout: a counter runs in ADDR, COUNT, DATA and CHK and clears on every `rx_valid`. When it reaches TIMEOUT idle cycles, go to FAIL with code 3.
- Bytes arriving during COMMIT or FAIL are dropped. They are not parsed as a new header.
- Address wrap: the RAM address wraps modulo 32. The buffer index never wraps because N≤32.

## Timing
- Reset values: `wraddress`=0, `data`=0, `wren`=0, `busy`=0, `done`=0, `err`=0, `err_code`=0; state IDLE, counters cleared.
- All outputs are registered.
- Commit timing: the checksum byte is sampled at edge T. `wren`=1 for the cycles following edges T+1 .. T+N, with `wraddress`/`data` valid in the same cycles. `done`=1 in the cycle after edge T+N+1, with `wren`=0.
- Rejection timing: `err` is high for one cycle, starting one edge after the offending byte or the timeout expiry. `err_code` updates in the same edge as `err`.
- `done` and `err` are never high together.
- `busy` rises the cycle after the header is accepted and falls in the same cycle as the `done`/`err` pulse.
- Back-to-back frames: the next header is accepted only once the state is IDLE, i.e. from the cycle `done`/`err` is asserted.
- Reset mid-frame or mid-commit: return to IDLE next edge with all outputs at reset values. Bytes already written to the RAM stay written.
- Back-to-back `rx_valid` on consecutive cycles is supported in all parsing states.

## Test plan
- Basic load: A5 00 04 11 22 33 44 40 -> writes 0:11, 1:22, 2:33, 3:44 on 4 consecutive cycles, then `done`; RAM readback at addresses 0..3 returns 11, 22, 33, 44.
- Wrap-around: A5 1E 03 AA BB CC C0 -> writes 30:AA, 31:BB, 0:CC; `done` pulses once.
- Bad checksum: A5 00 04 11 22 33 44 41 -> `err`=1 with `err_code`=2, `wren` never asserted, and prior RAM contents unchanged.
- Bad count: A5 00 00 -> `err` with code 1. A5 00 21 -> `err` with code 1. No writes in either case.
- Timeout, with TIMEOUT=100: A5 00 04 11 followed by 100 idle cycles -> `err` with code 3. A following valid frame then loads correctly.
- Noise and reset: bytes 00 FF 5A before a header are ignored. Asserting `reset` during COMMIT clears outputs within one edge and stops further writes.
